// File: rtl/debounce_pkg.sv
// Shared definitions for the multi-channel debouncer: FSM state encoding
// and a helper that decodes the debounced level from a state.
package debounce_pkg;

    typedef enum logic [1:0] {
        ZERO  = 2'b00,
        WAIT1 = 2'b01,
        ONE   = 2'b10,
        WAIT0 = 2'b11
    } state_t;

    // ONE and WAIT0 both still present the old/new high level to the outside.
    function automatic logic level_of(input state_t st);
        return (st == ONE) || (st == WAIT0);
    endfunction

endpackage

// File: rtl/debounce_chan.sv
// One debouncer channel: 2-flop synchroniser, four-state filter FSM with a
// stability counter, and Moore or Mealy rise/fall tick generation.
module debounce_chan
    import debounce_pkg::*;
#(
    parameter int STABLE = 4,
    parameter int MEALY  = 0
) (
    input  logic clk,
    input  logic reset,
    input  logic sw,
    input  logic sample_tick,
    output logic db_level,
    output logic rise_tick,
    output logic fall_tick
);

    localparam int CW = $clog2(STABLE);
    localparam logic [CW-1:0] CNT_LOAD = CW'(STABLE - 1);

    logic          sync_meta;
    logic          s;
    state_t        state;
    state_t        state_next;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_next;
    logic          cnt_zero;

    assign cnt_zero = (cnt == '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_meta <= 1'b0;
            s         <= 1'b0;
            state     <= ZERO;
            cnt       <= '0;
        end else begin
            sync_meta <= sw;
            s         <= sync_meta;
            state     <= state_next;
            cnt       <= cnt_next;
        end
    end

    // A bounce back to the settled level aborts a WAIT state regardless of sample_tick.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        unique case (state)
            ZERO: begin
                if (s) begin
                    state_next = WAIT1;
                    cnt_next   = CNT_LOAD;
                end
            end
            WAIT1: begin
                if (!s) begin
                    state_next = ZERO;
                end else if (sample_tick && cnt_zero) begin
                    state_next = ONE;
                end else if (sample_tick) begin
                    cnt_next = cnt - CW'(1);
                end
            end
            ONE: begin
                if (!s) begin
                    state_next = WAIT0;
                    cnt_next   = CNT_LOAD;
                end
            end
            WAIT0: begin
                if (s) begin
                    state_next = ONE;
                end else if (sample_tick && cnt_zero) begin
                    state_next = ZERO;
                end else if (sample_tick) begin
                    cnt_next = cnt - CW'(1);
                end
            end
            default: begin
                state_next = ZERO;
            end
        endcase
    end

    assign db_level = level_of(state) & ~reset;

    generate
        if (MEALY != 0) begin : g_mealy
            assign rise_tick = ~reset & (state == WAIT1) & s  & sample_tick & cnt_zero;
            assign fall_tick = ~reset & (state == WAIT0) & ~s & sample_tick & cnt_zero;
        end else begin : g_moore
            logic level_q;

            always_ff @(posedge clk) begin
                if (reset) begin
                    level_q <= 1'b0;
                end else begin
                    level_q <= db_level;
                end
            end

            assign rise_tick = ~reset & db_level  & ~level_q;
            assign fall_tick = ~reset & ~db_level & level_q;
        end
    endgenerate

endmodule

// File: rtl/debounce_edge_multi.sv
// N independent debouncer channels sharing clock, reset and the sample
// qualifier; each produces a clean level and single-cycle edge ticks.
module debounce_edge_multi
    import debounce_pkg::*;
#(
    parameter int N      = 4,
    parameter int STABLE = 4,
    parameter int MEALY  = 0
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [N-1:0] sw,
    input  logic         sample_tick,
    output logic [N-1:0] db_level,
    output logic [N-1:0] rise_tick,
    output logic [N-1:0] fall_tick
);

    genvar i;
    generate
        for (i = 0; i < N; i++) begin : g_chan
            debounce_chan #(
                .STABLE (STABLE),
                .MEALY  (MEALY)
            ) u_chan (
                .clk         (clk),
                .reset       (reset),
                .sw          (sw[i]),
                .sample_tick (sample_tick),
                .db_level    (db_level[i]),
                .rise_tick   (rise_tick[i]),
                .fall_tick   (fall_tick[i])
            );
        end
    endgenerate

endmodule
